// File: rtl/gate_sweep_pkg.sv
// Shared state encoding and reference truth tables for the gate sweep block.
// Bit i of each table is the expected gate output for input vector i.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOG,
        DONE
    } sweep_state_e;

    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;
    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_sweep_settle_timer.sv
// Loadable down-counter that marks the last cycle a vector is held on the gate.
// expire stays high once the count reaches zero, until the next load.
module gate_sweep_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(SETTLE + 1);
    localparam logic [W-1:0] RELOAD = W'(SETTLE - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/gate_truth_sweeper.sv
// Sweeps every input vector through a combinational gate, checks each sample
// against TRUTH and streams one log beat per vector with a pass/fail summary.
module gate_truth_sweeper
    import gate_sweep_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = TRUTH_NAND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            log_valid,
    input  logic            log_ready,
    output logic [N_IN-1:0] log_idx,
    output logic            log_y,
    output logic            log_mismatch
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(2**N_IN);

    sweep_state_e    state;
    sweep_state_e    next_state;
    logic [N_IN-1:0] idx;
    logic            expire;
    logic            load_timer;
    logic            last_vec;
    logic            mismatch;

    gate_sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_timer),
        .expire (expire)
    );

    assign last_vec = (idx == LAST_IDX);
    assign mismatch = (dut_out != TRUTH[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The settle timer is reloaded on every edge that enters DRIVE.
    always_comb begin
        next_state = state;
        load_timer = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                    load_timer = 1'b1;
                end
            end
            DRIVE: begin
                if (expire) begin
                    next_state = LOG;
                end
            end
            LOG: begin
                if (log_ready) begin
                    if (last_vec) begin
                        next_state = DONE;
                    end else begin
                        next_state = DRIVE;
                        load_timer = 1'b1;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state == DRIVE) || (state == LOG);
        done      = (state == DONE);
        log_valid = (state == LOG);
    end

    // idx stays at the last vector through the final handshake so the compare never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            log_y          <= 1'b0;
            log_mismatch   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= '0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        log_y        <= dut_out;
                        log_mismatch <= mismatch;
                        if (mismatch) begin
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (!fail_valid) begin
                                fail_valid     <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                    end
                end
                LOG: begin
                    if (log_ready) begin
                        if (last_vec) begin
                            pass <= (err_count == '0);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_in  = idx;
    assign log_idx = idx;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: a table-driven gate model sits on dut_in/dut_out and
// every sweep is checked against counts derived directly from the gate and truth tables.
module tb_gate_truth_sweeper;

    localparam logic [3:0] REF_TRUTH = 4'b0111;
    localparam int         REF_SETTLE = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       fail_valid;
    logic [1:0] first_fail_idx;
    logic       log_valid;
    logic       log_ready;
    logic [1:0] log_idx;
    logic       log_y;
    logic       log_mismatch;

    logic [3:0] gate_tbl;
    int         n_checks;
    int         n_fails;

    gate_truth_sweeper #(
        .N_IN   (2),
        .SETTLE (REF_SETTLE),
        .TRUTH  (REF_TRUTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .fail_valid     (fail_valid),
        .first_fail_idx (first_fail_idx),
        .log_valid      (log_valid),
        .log_ready      (log_ready),
        .log_idx        (log_idx),
        .log_y          (log_y),
        .log_mismatch   (log_mismatch)
    );

    assign dut_out = gate_tbl[dut_in];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // ready_mode: 0 = always ready, 1 = random back-pressure, 2 = five-cycle stall on beat 2.
    task automatic applyStimulus(input logic [3:0] tbl, input int ready_mode, input bit poke_start);
        logic [3:0] diff;
        int         exp_err;
        int         exp_first;
        int         cyc;
        int         stalls;
        int         beats;
        int         stall_left;
        logic       r;

        gate_tbl  = tbl;
        diff      = tbl ^ REF_TRUTH;
        exp_err   = $countones(diff);
        exp_first = 0;
        for (int i = 3; i >= 0; i--) begin
            if (diff[i]) exp_first = i;
        end

        @(negedge clk);
        start     = 1'b1;
        log_ready = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 0;
        stalls     = 0;
        beats      = 0;
        stall_left = 5;

        while (cyc < 200) begin
            if (done) break;
            start = (poke_start && cyc == 5);
            checkOutput("busy_in_sweep", busy, 1);
            if (log_valid) begin
                checkOutput("log_idx", log_idx, beats);
                checkOutput("log_y", log_y, tbl[beats]);
                checkOutput("log_mismatch", log_mismatch, diff[beats]);
                checkOutput("dut_in_during_log", dut_in, beats);
                case (ready_mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 3) != 0);
                    default: r = !(beats == 2 && stall_left > 0);
                endcase
                if (r) begin
                    beats++;
                end else begin
                    stalls++;
                    if (beats == 2) stall_left--;
                end
                log_ready = r;
            end else begin
                log_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        if (!done) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("done_latency", cyc, 4 * (REF_SETTLE + 1) + stalls);
            checkOutput("beat_count", beats, 4);
            checkOutput("busy_in_done", busy, 0);
            checkOutput("pass", pass, (exp_err == 0));
            checkOutput("err_count", err_count, exp_err);
            checkOutput("fail_valid", fail_valid, (exp_err != 0));
            checkOutput("first_fail_idx", first_fail_idx, exp_first);
        end

        start     = poke_start;
        log_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_single_pulse", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_dut_in", dut_in, 0);
        checkOutput("idle_log_valid", log_valid, 0);
        checkOutput("pass_held", pass, (exp_err == 0));
        @(negedge clk);
        checkOutput("start_not_queued", busy, 0);
    endtask

    task automatic applyResetMidSweep();
        int n;
        gate_tbl = 4'b1000;
        @(negedge clk);
        start     = 1'b1;
        log_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (!(busy && !log_valid && dut_in == 2'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_drive_idx1", (n < 50), 1);
        checkOutput("err_before_reset", err_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_log_valid", log_valid, 0);
        checkOutput("rst_dut_in", dut_in, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_fail_valid", fail_valid, 0);
        checkOutput("rst_done", done, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        log_ready = 1'b0;
        gate_tbl  = 4'b0111;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_pass", pass, 0);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_fail_valid", fail_valid, 0);
        checkOutput("reset_first_fail_idx", first_fail_idx, 0);
        checkOutput("reset_log_valid", log_valid, 0);
        checkOutput("reset_dut_in", dut_in, 0);
        checkOutput("reset_log_idx", log_idx, 0);
        checkOutput("reset_log_y", log_y, 0);
        checkOutput("reset_log_mismatch", log_mismatch, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] NAND2 gate, log_ready held high");
        applyStimulus(4'b0111, 0, 1'b0);
        $display("[TB] AND2 gate against NAND2 table");
        applyStimulus(4'b1000, 0, 1'b0);
        $display("[TB] constant-1 gate");
        applyStimulus(4'b1111, 0, 1'b0);
        $display("[TB] five-cycle stall on beat 2");
        applyStimulus(4'b0111, 2, 1'b0);
        $display("[TB] reset while driving vector 1, then clean sweep");
        applyResetMidSweep();
        applyStimulus(4'b0111, 0, 1'b0);
        $display("[TB] start pulsed while busy and in DONE");
        applyStimulus(4'b0111, 0, 1'b1);
        applyStimulus(4'b0111, 0, 1'b0);
        $display("[TB] random gates with random back-pressure");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
